// File: rtl/fft_rx_pkg.sv
// fft_rx_pkg: sizing, FSM encoding and saturating-abs helper for the FFT spectrum receiver.
package fft_rx_pkg;
    localparam int FFT_LEN = 256;
    localparam int ADDR_W  = $clog2(FFT_LEN);
    localparam int MAG_W   = 16;

    typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

    // -32768 has no positive twin in 16 bits, so it clamps to 32767
    function automatic logic [14:0] sat_abs(input logic [15:0] v);
        logic [15:0] n;
        n = -v;
        return v[15] ? ((v == 16'h8000) ? 15'h7fff : n[14:0]) : v[14:0];
    endfunction
endpackage

// File: rtl/fft_spectrum_rx_if.sv
// fft_spectrum_rx_if: FFT beat stream in, display read port and frame status out.
interface fft_spectrum_rx_if;
    import fft_rx_pkg::*;
    logic [31:0]       fft_data;
    logic              fft_sop;
    logic              fft_eop;
    logic              fft_valid;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [MAG_W-1:0]  rd_data;
    logic              buf_valid;
    logic              frame_done;
    logic              frame_err;
    logic [15:0]       frame_cnt;

    modport master (
        output fft_data, fft_sop, fft_eop, fft_valid, rd_en, rd_addr,
        input  rd_data, buf_valid, frame_done, frame_err, frame_cnt
    );
    modport slave (
        input  fft_data, fft_sop, fft_eop, fft_valid, rd_en, rd_addr,
        output rd_data, buf_valid, frame_done, frame_err, frame_cnt
    );
endinterface

// File: rtl/fft_mag_approx.sv
// fft_mag_approx: two-stage |re|,|im| then max + min/2 magnitude, with valid/address sideband.
module fft_mag_approx
    import fft_rx_pkg::*;
(
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic             i_valid,
    input  logic [ADDR_W:0]  i_addr,
    input  logic [31:0]      i_data,
    output logic             o_valid,
    output logic [ADDR_W:0]  o_addr,
    output logic [MAG_W-1:0] o_mag
);
    logic             r_valid;
    logic [ADDR_W:0]  r_addr;
    logic [14:0]      r_re, r_im;
    logic [14:0]      w_max, w_min;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_re    <= '0;
            r_im    <= '0;
        end else begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_addr <= i_addr;
                r_re   <= sat_abs(i_data[15:0]);
                r_im   <= sat_abs(i_data[31:16]);
            end
        end
    end

    assign w_max   = (r_re > r_im) ? r_re : r_im;
    assign w_min   = (r_re > r_im) ? r_im : r_re;
    assign o_valid = r_valid;
    assign o_addr  = r_addr;
    assign o_mag   = MAG_W'({1'b0, w_max}) + MAG_W'(w_min >> 1);
endmodule

// File: rtl/fft_spectrum_rx.sv
// fft_spectrum_rx: frames FFT bins into a ping-pong magnitude buffer and serves the last committed frame.
module fft_spectrum_rx
    import fft_rx_pkg::*;
(
    input  logic             sys_clk,
    input  logic             rst_n,
    fft_spectrum_rx_if.slave bus
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FFT_LEN - 1);

    state_t            r_state, w_state_nx;
    logic [ADDR_W-1:0] r_idx, w_idx_nx, w_waddr;
    logic              w_wr, w_err, w_accept;
    logic              r_fill_bank, r_rd_bank, r_buf_valid, r_err;
    logic [1:0]        r_cpend, r_cbank;
    logic [15:0]       r_cnt;
    logic [MAG_W-1:0]  r_rd_data, w_mag;
    logic              w_mwe;
    logic [ADDR_W:0]   w_maddr;
    logic [MAG_W-1:0]  r_ram [2*FFT_LEN];

    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_waddr    = r_idx;
        w_wr       = 1'b0;
        w_err      = 1'b0;
        w_accept   = 1'b0;
        if (bus.fft_valid) begin
            if (bus.fft_sop && bus.fft_eop) begin
                w_err      = 1'b1;
                w_state_nx = IDLE;
            end else if (bus.fft_sop) begin
                // a restart only counts as an error when it cuts a frame short
                w_err      = (r_state == RECV);
                w_wr       = 1'b1;
                w_waddr    = '0;
                w_idx_nx   = ADDR_W'(1);
                w_state_nx = RECV;
            end else if (r_state == RECV) begin
                if (bus.fft_eop) begin
                    w_wr       = (r_idx == LAST);
                    w_accept   = (r_idx == LAST);
                    w_err      = (r_idx != LAST);
                    w_state_nx = IDLE;
                end else if (r_idx == LAST) begin
                    w_err      = 1'b1;
                    w_state_nx = DROP;
                end else begin
                    w_wr     = 1'b1;
                    w_idx_nx = r_idx + ADDR_W'(1);
                end
            end else if (r_state == DROP && bus.fft_eop) begin
                w_state_nx = IDLE;
            end
        end
    end

    fft_mag_approx u_mag (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .i_valid (w_wr),
        .i_addr  ({r_fill_bank, w_waddr}),
        .i_data  (bus.fft_data),
        .o_valid (w_mwe),
        .o_addr  (w_maddr),
        .o_mag   (w_mag)
    );

    always_ff @(posedge sys_clk) begin
        if (w_mwe) r_ram[w_maddr] <= w_mag;
    end

    // fill bank flips at accept so a back-to-back frame lands in the other bank;
    // the read bank follows two cycles later, once the last bin has been written
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_fill_bank <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_buf_valid <= 1'b0;
            r_err       <= 1'b0;
            r_cpend     <= '0;
            r_cbank     <= '0;
            r_cnt       <= '0;
            r_rd_data   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
            r_err   <= w_err;
            r_cpend <= {r_cpend[0], w_accept};
            r_cbank <= {r_cbank[0], r_fill_bank};
            if (w_accept) r_fill_bank <= ~r_fill_bank;
            if (r_cpend[1]) begin
                r_rd_bank   <= r_cbank[1];
                r_buf_valid <= 1'b1;
                r_cnt       <= r_cnt + 16'd1;
            end
            if (bus.rd_en) r_rd_data <= r_buf_valid ? r_ram[{r_rd_bank, bus.rd_addr}] : '0;
        end
    end

    assign bus.rd_data    = r_rd_data;
    assign bus.buf_valid  = r_buf_valid;
    assign bus.frame_done = r_cpend[1];
    assign bus.frame_err  = r_err;
    assign bus.frame_cnt  = r_cnt;
endmodule

// File: tb/tb_fft_spectrum_rx.sv
// tb_fft_spectrum_rx: randomized frame traffic checked cycle by cycle against a frame-level reference model.
module tb_fft_spectrum_rx;
    import fft_rx_pkg::*;

    logic sys_clk = 1'b0;
    logic rst_n   = 1'b0;
    int n_pass = 0, n_chk = 0, n_errs = 0, gaps = 0;
    int edge_k = 0, m_pos = -1, done_at = -1, commit_at = -1;
    int done_edges[$];
    logic [31:0] fd[512];
    int cur[FFT_LEN], pend[FFT_LEN], good[FFT_LEN];
    logic m_valid = 1'b0, m_err = 1'b0, m_done = 1'b0;
    logic [15:0] m_cnt = '0, m_rd = '0;

    fft_spectrum_rx_if bus();

    fft_spectrum_rx dut (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #10 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int ref_mag(input logic [31:0] d);
        int re, im, hi, lo;
        re = int'($signed(d[15:0]));
        im = int'($signed(d[31:16]));
        re = (re < 0) ? -re : re;
        im = (im < 0) ? -im : im;
        if (re > 32767) re = 32767;
        if (im > 32767) im = 32767;
        hi = (re > im) ? re : im;
        lo = (re > im) ? im : re;
        return hi + lo / 2;
    endfunction

    // pos: -1 outside a frame, -2 discarding to eop, else bins collected so far
    task automatic model_edge();
        int mg;
        edge_k++;
        m_err = 1'b0;
        if (!rst_n) begin
            m_pos = -1; done_at = -1; commit_at = -1;
            m_valid = 1'b0; m_cnt = '0; m_rd = '0; m_done = 1'b0;
            return;
        end
        if (bus.rd_en) m_rd = m_valid ? 16'(good[bus.rd_addr]) : 16'd0;
        if (edge_k == commit_at) begin
            good = pend;
            m_valid = 1'b1;
            m_cnt++;
        end
        if (bus.fft_valid) begin
            mg = ref_mag(bus.fft_data);
            if (bus.fft_sop && bus.fft_eop) begin
                m_err = 1'b1; m_pos = -1;
            end else if (bus.fft_sop) begin
                m_err = (m_pos >= 0);
                cur[0] = mg; m_pos = 1;
            end else if (m_pos >= 0) begin
                if (bus.fft_eop) begin
                    if (m_pos == FFT_LEN - 1) begin
                        cur[m_pos] = mg; pend = cur;
                        done_at = edge_k + 1; commit_at = edge_k + 2;
                    end else m_err = 1'b1;
                    m_pos = -1;
                end else if (m_pos == FFT_LEN - 1) begin
                    m_err = 1'b1; m_pos = -2;
                end else begin
                    cur[m_pos] = mg; m_pos++;
                end
            end else if (m_pos == -2 && bus.fft_eop) m_pos = -1;
        end
        m_done = (edge_k == done_at);
    endtask

    task automatic compare();
        chk("frame_err", 32'(bus.frame_err), 32'(m_err));
        chk("frame_done", 32'(bus.frame_done), 32'(m_done));
        chk("buf_valid", 32'(bus.buf_valid), 32'(m_valid));
        chk("frame_cnt", 32'(bus.frame_cnt), 32'(m_cnt));
        chk("rd_data", 32'(bus.rd_data), 32'(m_rd));
        if (bus.frame_err) n_errs++;
        if (bus.frame_done) done_edges.push_back(edge_k);
    endtask

    task automatic cyc(input logic v, input logic s, input logic e, input logic [31:0] d,
                       input logic re, input logic [ADDR_W-1:0] ra);
        bus.fft_valid = v; bus.fft_sop = s; bus.fft_eop = e; bus.fft_data = d;
        bus.rd_en = re; bus.rd_addr = ra;
        @(posedge sys_clk);
        model_edge();
        @(negedge sys_clk);
        compare();
    endtask

    task automatic idle();
        cyc(1'b0, 1'($urandom), 1'($urandom), $urandom, 1'($urandom), ADDR_W'($urandom));
    endtask

    task automatic rdc(input int a);
        cyc(1'b0, 1'b0, 1'b0, $urandom, 1'b1, ADDR_W'(a));
    endtask

    task automatic beat(input logic s, input logic e, input logic [31:0] d);
        if (gaps == 2) idle();
        else if (gaps == 1) while ($urandom_range(0, 3) == 0) idle();
        cyc(1'b1, s, e, d, 1'($urandom), ADDR_W'($urandom));
    endtask

    task automatic frame(input int len, input bit with_eop);
        for (int k = 0; k < len; k++) beat(k == 0, with_eop && k == len - 1, fd[k]);
    endtask

    task automatic fill_ramp();
        for (int k = 0; k < 512; k++) fd[k] = 32'(k % FFT_LEN);
    endtask

    task automatic fill_rand();
        for (int k = 0; k < 512; k++) fd[k] = $urandom;
    endtask

    initial begin
        bus.fft_valid = 1'b0; bus.fft_sop = 1'b0; bus.fft_eop = 1'b0;
        bus.fft_data = '0; bus.rd_en = 1'b0; bus.rd_addr = '0;
        repeat (3) idle();
        chk("rst_buf_valid", 32'(bus.buf_valid), 32'd0);
        chk("rst_cnt", 32'(bus.frame_cnt), 32'd0);
        chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
        rst_n = 1'b1;
        idle();

        fill_ramp();
        gaps = 0;
        frame(256, 1'b1);
        idle();
        chk("t1_done_latency", 32'(bus.frame_done), 32'd1);
        idle(); idle();
        chk("t1_cnt", 32'(bus.frame_cnt), 32'd1);
        chk("t1_buf_valid", 32'(bus.buf_valid), 32'd1);
        rdc(10);
        chk("t1_rd10", 32'(bus.rd_data), 32'd10);

        fill_rand();
        fd[0] = {16'hfffd, 16'h0004};
        fd[1] = {16'h0000, 16'h8000};
        fd[2] = {16'h8000, 16'h8000};
        gaps = 1;
        frame(256, 1'b1);
        repeat (3) idle();
        rdc(0); chk("t2_mag_5", 32'(bus.rd_data), 32'd5);
        rdc(1); chk("t2_mag_sat", 32'(bus.rd_data), 32'd32767);
        rdc(2); chk("t2_mag_max", 32'(bus.rd_data), 32'd49150);

        fill_rand();
        n_errs = 0;
        frame(101, 1'b1);
        repeat (3) idle();
        chk("t3_errs", 32'(n_errs), 32'd1);
        chk("t3_cnt", 32'(bus.frame_cnt), 32'd2);
        rdc(2); chk("t3_keeps_old", 32'(bus.rd_data), 32'd49150);

        n_errs = 0;
        frame(300, 1'b1);
        repeat (3) idle();
        chk("t4_errs", 32'(n_errs), 32'd1);
        chk("t4_cnt", 32'(bus.frame_cnt), 32'd2);
        frame(256, 1'b1);
        repeat (3) idle();
        chk("t4_recover_cnt", 32'(bus.frame_cnt), 32'd3);

        fill_ramp();
        gaps = 2;
        frame(256, 1'b1);
        repeat (3) idle();
        for (int k = 0; k < FFT_LEN; k++) begin
            rdc(k);
            chk("t5_ram", 32'(bus.rd_data), 32'(k));
        end

        fill_rand();
        gaps = 1;
        frame(128, 1'b0);
        rst_n = 1'b0;
        idle();
        chk("t6_buf_valid", 32'(bus.buf_valid), 32'd0);
        chk("t6_cnt", 32'(bus.frame_cnt), 32'd0);
        chk("t6_rd_data", 32'(bus.rd_data), 32'd0);
        idle();
        rst_n = 1'b1;
        n_errs = 0;
        frame(256, 1'b1);
        repeat (3) idle();
        chk("t6_cnt_after", 32'(bus.frame_cnt), 32'd1);
        chk("t6_no_err", 32'(n_errs), 32'd0);

        n_errs = 0;
        fill_rand();
        frame(50, 1'b0);
        fill_rand();
        frame(256, 1'b1);
        repeat (3) idle();
        chk("t7_errs", 32'(n_errs), 32'd1);
        chk("t7_cnt", 32'(bus.frame_cnt), 32'd2);

        gaps = 0;
        done_edges.delete();
        fill_rand();
        frame(256, 1'b1);
        fill_ramp();
        frame(256, 1'b1);
        repeat (3) idle();
        chk("t8_pulses", 32'(done_edges.size()), 32'd2);
        if (done_edges.size() == 2)
            chk("t8_spacing", 32'(done_edges[1] - done_edges[0]), 32'd256);
        chk("t8_cnt", 32'(bus.frame_cnt), 32'd4);
        rdc(77); chk("t8_bank", 32'(bus.rd_data), 32'd77);

        gaps = 1;
        repeat (4) begin
            fill_rand();
            frame(256, 1'b1);
            repeat (300) begin
                int r;
                r = $urandom_range(0, 99);
                beat(r < 2, r >= 2 && r < 4, $urandom);
            end
        end
        repeat (5) idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
